nv_asyncfifo_wr_cg_ctrl: RTL and testbench
==========================================

NV_ASYNCFIFO_WR_CG_CTRL -- requirements
Module: nv_asyncfifo_wr_cg_ctrl

Interface
REQ-001 Parameter HOLD_W, default 4, width of the idle-hold configuration field.
REQ-002 Parameter CNT_W, default 16, width of the wake-event statistics counter.
REQ-003 nvdla_core_clk  input  1  single clock for all logic.
REQ-004 nvdla_core_rst  input  1  reset, synchronous, active-high.
REQ-005 wr_req  input  1  requester wants to write the async FIFO this cycle.
REQ-006 fifo_wr_busy  input  1  write-side work in flight (pointer sync / pending data).
REQ-007 dft_enable_w  input  1  DFT write-clock enable; 1 in functional mode.
REQ-008 cfg_cg_disable  input  1  1 = clock gating off; the block behaves as if wr_req is held high.
REQ-009 cfg_hold_cycles  input  HOLD_W  idle cycles to keep the clock on before gating.
REQ-010 clk_en_w  output  1  enable to the FIFO write-side clock gate.
REQ-011 wr_ready  output  1  write accepted this cycle when wr_req & wr_ready.
REQ-012 cg_state  output  2  current FSM state encoding.
REQ-013 wake_cnt  output  CNT_W  count of OFF->WAKE transitions.

Function
REQ-014 FSM states: OFF=0, WAKE=1, ON=2, HOLD=3; cg_state equals the registered state.
REQ-015 Define act = wr_req | fifo_wr_busy | cfg_cg_disable.
REQ-016 OFF: if act, go to WAKE; else stay in OFF.
REQ-017 WAKE: always lasts exactly 1 cycle, then goes to ON; this covers clock-gate latency.
REQ-018 ON: if act, stay in ON; else go to HOLD and load hold_cnt <= cfg_hold_cycles.
REQ-019 HOLD: if act, go to ON (hold_cnt don't-care).
REQ-020 HOLD: else, if hold_cnt==0, go to OFF.
REQ-021 HOLD: else, decrement hold_cnt.
REQ-022 With cfg_hold_cycles=N, an idle requester sees N+1 HOLD cycles before OFF; N=0 gives 1 HOLD cycle.
REQ-023 fsm_en is a register, 1 when the next state is WAKE, ON or HOLD; clk_en_w = fsm_en & dft_enable_w.
REQ-024 Latency: wr_req rising in OFF gives clk_en_w=1 on the next cycle and wr_ready=1 two cycles after the request.
REQ-025 wr_ready = (state==ON | state==HOLD) & dft_enable_w; it is never 1 in OFF or WAKE.
REQ-026 Requester holds wr_req until wr_req & wr_ready; the block never drops wr_ready while in ON with wr_req high.
REQ-027 dft_enable_w=0 forces clk_en_w=0 and wr_ready=0 combinationally.
REQ-028 dft_enable_w does not alter FSM state or counters.
REQ-029 wake_cnt increments on each OFF->WAKE transition.
REQ-030 wake_cnt saturates at all-ones and does not wrap.
REQ-031 cfg_hold_cycles is sampled only when entering HOLD; changes during HOLD take effect on the next entry.
REQ-032 cfg_cg_disable asserted in any state drives the FSM to ON via the normal path (OFF->WAKE->ON, HOLD->ON).

Reset
REQ-033 On nvdla_core_rst=1 at a clock edge: state=OFF, fsm_en=0, hold_cnt=0, wake_cnt=0.
REQ-034 During and after reset, clk_en_w=0, wr_ready=0 and cg_state=0 until the FSM leaves OFF.
REQ-035 Reset asserted mid-operation (WAKE/ON/HOLD) returns to OFF on the next edge.
REQ-036 A reset cycle does not increment wake_cnt.
REQ-037 With wr_req held high through reset release, WAKE occurs on the first post-reset edge.

Structure
REQ-038 Shared package nv_asyncfifo_cg_pkg holds the state enum (OFF/WAKE/ON/HOLD) plus HOLD_W and CNT_W defaults.
REQ-039 One sub-module, nv_cg_hold_cnt (load / decrement / zero flag), implements the hold counter.
REQ-040 The FSM, fsm_en register, output logic and wake_cnt live in the top module.

Verification
REQ-041 Reset, then wr_req=1 at cycle 0 -> cg_state WAKE at 1, clk_en_w=1 at 1, wr_ready=1 at 2, wake_cnt=1.
REQ-042 cfg_hold_cycles=3, drop wr_req and fifo_wr_busy in ON -> 4 HOLD cycles, then OFF with clk_en_w=0.
REQ-043 wr_req re-asserted in the 2nd HOLD cycle -> ON next cycle, no WAKE, wake_cnt unchanged.
REQ-044 dft_enable_w=0 while in ON with wr_req=1 -> clk_en_w=0 and wr_ready=0 same cycle, cg_state stays ON; restore -> both 1 again.
REQ-045 cfg_cg_disable=1 with all requests idle -> OFF->WAKE->ON and remains in ON indefinitely; clear it -> HOLD then OFF.
REQ-046 CNT_W=2, 5 wake cycles -> wake_cnt=3 (saturated); reset asserted in HOLD -> OFF next edge and wake_cnt=0.

Source files
------------

// File: rtl/nv_asyncfifo_cg_pkg.sv
// Shared definitions for the async-FIFO write-side clock-gating controller.
package nv_asyncfifo_cg_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_HOLD = 2'd3
    } cg_state_e;

    localparam int HOLD_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/nv_cg_hold_cnt.sv
// Idle-hold down-counter: loaded on entry to HOLD, decremented while idle,
// reports when it has run out so the FSM can gate the clock.
module nv_cg_hold_cnt
    import nv_asyncfifo_cg_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              dec_i,
    input  logic [HOLD_W-1:0] load_val_i,
    output logic              zero_o
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Load has priority over decrement; otherwise the count holds.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    // Counter register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nv_asyncfifo_wr_cg_ctrl.sv
// Write-side clock-gate controller for an async FIFO. A four-state FSM
// (OFF/WAKE/ON/HOLD) turns the write clock on for requests, gives the gate
// one WAKE cycle to settle before accepting writes, and keeps the clock on
// for a programmable number of idle cycles before gating it again.
module nv_asyncfifo_wr_cg_ctrl
    import nv_asyncfifo_cg_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              wr_req,
    input  logic              fifo_wr_busy,
    input  logic              dft_enable_w,
    input  logic              cfg_cg_disable,
    input  logic [HOLD_W-1:0] cfg_hold_cycles,
    output logic              clk_en_w,
    output logic              wr_ready,
    output logic [1:0]        cg_state,
    output logic [CNT_W-1:0]  wake_cnt
);

    cg_state_e        state_q;
    cg_state_e        state_d;
    logic             fsm_en_q;
    logic [CNT_W-1:0] wake_cnt_q;
    logic [CNT_W-1:0] wake_cnt_d;
    logic             act;
    logic             hold_load;
    logic             hold_dec;
    logic             hold_zero;

    // Saturating increment: the statistic sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Disabling gating is treated as a permanent request.
    assign act = wr_req | fifo_wr_busy | cfg_cg_disable;

    nv_cg_hold_cnt #(
        .HOLD_W (HOLD_W)
    ) u_hold_cnt (
        .clk        (nvdla_core_clk),
        .rst        (nvdla_core_rst),
        .load_i     (hold_load),
        .dec_i      (hold_dec),
        .load_val_i (cfg_hold_cycles),
        .zero_o     (hold_zero)
    );

    // State register; fsm_en is registered alongside so the gate enable
    // follows the state that is about to be entered.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q  <= CG_OFF;
            fsm_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fsm_en_q <= (state_d != CG_OFF);
        end
    end

    // Next-state logic and hold-counter control.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        case (state_q)
            CG_OFF: begin
                if (act) begin
                    state_d = CG_WAKE;
                end
            end
            CG_WAKE: begin
                state_d = CG_ON;
            end
            CG_ON: begin
                if (!act) begin
                    state_d   = CG_HOLD;
                    hold_load = 1'b1;
                end
            end
            CG_HOLD: begin
                if (act) begin
                    state_d = CG_ON;
                end else if (hold_zero) begin
                    state_d = CG_OFF;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            default: begin
                state_d = CG_OFF;
            end
        endcase
    end

    // Count each wake-up, i.e. every OFF->WAKE transition.
    always_comb begin
        wake_cnt_d = wake_cnt_q;
        if ((state_q == CG_OFF) && act) begin
            wake_cnt_d = sat_inc(wake_cnt_q);
        end
    end

    // Wake statistic register; reset wins so a reset cycle never counts.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wake_cnt_q <= '0;
        end else begin
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Outputs; DFT enable masks the gate and handshake without touching state.
    always_comb begin
        clk_en_w = fsm_en_q & dft_enable_w;
        wr_ready = ((state_q == CG_ON) || (state_q == CG_HOLD)) & dft_enable_w;
        cg_state = state_q;
        wake_cnt = wake_cnt_q;
    end

endmodule

// File: tb/tb_nv_asyncfifo_wr_cg_ctrl.sv
// Bench for the write-side clock-gate controller (wake counter narrowed to
// 2 bits so saturation is reachable in a few wake-ups).
module tb_nv_asyncfifo_wr_cg_ctrl;

    localparam int HW = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic          rst;
        logic          req;
        logic          busy;
        logic          dft;
        logic          dis;
        logic [HW-1:0] hold;
        logic [1:0]    st;
        logic          ce;
        logic          rd;
        logic [CW-1:0] wk;
    } vec_t;

    typedef struct packed {
        logic [1:0]    st;
        logic          ce;
        logic          rd;
        logic [CW-1:0] wk;
    } exp_t;

    logic          clk;
    logic          rst_r;
    logic          req_r;
    logic          busy_r;
    logic          dft_r;
    logic          dis_r;
    logic [HW-1:0] hold_r;
    logic          clk_en_w;
    logic          wr_ready;
    logic [1:0]    cg_state;
    logic [CW-1:0] wake_cnt;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    nv_asyncfifo_wr_cg_ctrl #(
        .HOLD_W (HW),
        .CNT_W  (CW)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rst  (rst_r),
        .wr_req          (req_r),
        .fifo_wr_busy    (busy_r),
        .dft_enable_w    (dft_r),
        .cfg_cg_disable  (dis_r),
        .cfg_hold_cycles (hold_r),
        .clk_en_w        (clk_en_w),
        .wr_ready        (wr_ready),
        .cg_state        (cg_state),
        .wake_cnt        (wake_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r, input logic q, input logic b,
                                input logic d, input logic s, input int h,
                                input int st, input logic ce, input logic rd,
                                input int wk);
        vec_t v;
        v.rst  = r;
        v.req  = q;
        v.busy = b;
        v.dft  = d;
        v.dis  = s;
        v.hold = HW'(h);
        v.st   = 2'(st);
        v.ce   = ce;
        v.rd   = rd;
        v.wk   = CW'(wk);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        rst_r  = v.rst;
        req_r  = v.req;
        busy_r = v.busy;
        dft_r  = v.dft;
        dis_r  = v.dis;
        hold_r = v.hold;
        exp_q.push_back({v.st, v.ce, v.rd, v.wk});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".cg_state"}, int'(cg_state), int'(e.st));
        chk({tag, ".clk_en_w"}, int'(clk_en_w), int'(e.ce));
        chk({tag, ".wr_ready"}, int'(wr_ready), int'(e.rd));
        chk({tag, ".wake_cnt"}, int'(wake_cnt), int'(e.wk));
    endtask

    initial begin
        rst_r  = 1'b1;
        req_r  = 1'b0;
        busy_r = 1'b0;
        dft_r  = 1'b1;
        dis_r  = 1'b0;
        hold_r = '0;

        //                  rst req bsy dft dis hold   st ce rd wk
        // reset, request held through reset release
        vecs.push_back(mk(1, 0, 0, 1, 0, 3,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 3,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   2, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   2, 1, 1, 1));
        // idle with hold=3: four HOLD cycles then OFF
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   0, 0, 0, 1));
        // request back in the 2nd HOLD cycle: straight to ON, no wake
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   1, 1, 0, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   2, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   3, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3,   3, 1, 1, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   2, 1, 1, 2));
        // DFT enable low in ON masks outputs, state kept
        vecs.push_back(mk(0, 1, 0, 0, 0, 3,   2, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3,   2, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3,   2, 1, 1, 2));
        // hold=0 gives exactly one HOLD cycle
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   3, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 2));
        // gating disabled: wake and stay ON, then release
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   1, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   2, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   2, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   2, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   2, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   3, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 3));
        // busy alone wakes; wake counter saturated at 3
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1, 0, 3));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,   2, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   3, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   1, 1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   2, 1, 1, 3));
        // reset while in HOLD clears state and counter
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,   3, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,   3, 1, 1, 3));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,   0, 0, 0, 0));
        // hold config changed during HOLD is ignored until next entry
        vecs.push_back(mk(0, 1, 0, 1, 0, 2,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 2,   2, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 1));
        // FSM advances with DFT enable low, outputs masked
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   2, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   2, 1, 1, 2));
        // reset while in ON
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("row%0d", i));
        end

        // Combinational DFT masking inside one ON cycle.
        step(mk(0, 1, 0, 1, 0, 0,   1, 1, 0, 1), "hs0");
        step(mk(0, 1, 0, 1, 0, 0,   2, 1, 1, 1), "hs1");
        dft_r = 1'b0;
        #2;
        chk("hs_dft0.clk_en_w", int'(clk_en_w), 0);
        chk("hs_dft0.wr_ready", int'(wr_ready), 0);
        chk("hs_dft0.cg_state", int'(cg_state), 2);
        dft_r = 1'b1;
        #2;
        chk("hs_dft1.clk_en_w", int'(clk_en_w), 1);
        chk("hs_dft1.wr_ready", int'(wr_ready), 1);
        chk("hs_dft1.cg_state", int'(cg_state), 2);
        step(mk(0, 0, 0, 1, 0, 0,   3, 1, 1, 1), "hs2");
        step(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 1), "hs3");

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
